// File: rtl/ram_arbiter.sv
// Two-master round-robin arbiter in front of a single-port synchronous RAM.
// Each granted request runs IDLE -> ACCESS -> (WAIT x RD_LAT for reads) -> DONE.
module ram_arbiter #(
    parameter int AW     = 16,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_di,
    input  logic [DW-1:0] mem_do
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ACCESS   = 2'd1;
    localparam logic [1:0] WAIT     = 2'd2;
    localparam logic [1:0] DONE     = 2'd3;
    localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

    logic [1:0] state_r;
    logic       last_grant_r;
    logic       grant_r;
    logic       lat_we_r;
    logic [1:0] cnt_r;
    logic       grant_valid_s;
    logic       winner_s;

    // Arbitration: a lone requester wins, a tie goes to the master not served last.
    always_comb begin
        grant_valid_s = 1'b0;
        winner_s      = 1'b0;
        if (m0_req && m1_req) begin
            grant_valid_s = 1'b1;
            winner_s      = ~last_grant_r;
        end else if (m0_req) begin
            grant_valid_s = 1'b1;
            winner_s      = 1'b0;
        end else if (m1_req) begin
            grant_valid_s = 1'b1;
            winner_s      = 1'b1;
        end else begin
            grant_valid_s = 1'b0;
            winner_s      = 1'b0;
        end
    end

    // Transaction sequencer; RAM pins are registered at the grant edge so they are valid during ACCESS.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            grant_r      <= 1'b0;
            lat_we_r     <= 1'b0;
            cnt_r        <= 2'd0;
            m0_ack       <= 1'b0;
            m1_ack       <= 1'b0;
            m0_rdata     <= {DW{1'b0}};
            m1_rdata     <= {DW{1'b0}};
            mem_addr     <= {AW{1'b0}};
            mem_we       <= 1'b0;
            mem_di       <= {DW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    m0_ack <= 1'b0;
                    m1_ack <= 1'b0;
                    if (grant_valid_s) begin
                        grant_r      <= winner_s;
                        last_grant_r <= winner_s;
                        lat_we_r     <= winner_s ? m1_we : m0_we;
                        mem_we       <= winner_s ? m1_we : m0_we;
                        mem_addr     <= winner_s ? m1_addr : m0_addr;
                        mem_di       <= winner_s ? m1_wdata : m0_wdata;
                        state_r      <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_we <= 1'b0;
                    if (lat_we_r) begin
                        m0_ack  <= ~grant_r;
                        m1_ack  <= grant_r;
                        state_r <= DONE;
                    end else begin
                        cnt_r   <= LAT_LOAD;
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    mem_we <= 1'b0;
                    if (cnt_r == 2'd0) begin
                        if (grant_r) begin
                            m1_rdata <= mem_do;
                        end else begin
                            m0_rdata <= mem_do;
                        end
                        m0_ack  <= ~grant_r;
                        m1_ack  <= grant_r;
                        state_r <= DONE;
                    end else begin
                        cnt_r <= cnt_r - 2'd1;
                    end
                end
                DONE: begin
                    m0_ack  <= 1'b0;
                    m1_ack  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    m0_ack  <= 1'b0;
                    m1_ack  <= 1'b0;
                    mem_we  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: an RD_LAT=1 instance for most scenarios
// and an RD_LAT=3 instance for the long-latency read, each with a RAM model.
module tb_ram_arbiter;

    logic        clk;
    logic        rst;
    int          errors;
    int          checks;

    logic        m0_req, m0_we, m0_ack, m1_req, m1_we, m1_ack, mem_we;
    logic [15:0] m0_addr, m1_addr, mem_addr;
    logic [7:0]  m0_wdata, m1_wdata, m0_rdata, m1_rdata, mem_di, mem_do;

    logic        b_m0_req, b_m0_we, b_m0_ack, b_m1_req, b_m1_we, b_m1_ack, b_mem_we;
    logic [15:0] b_m0_addr, b_m1_addr, b_mem_addr;
    logic [7:0]  b_m0_wdata, b_m1_wdata, b_m0_rdata, b_m1_rdata, b_mem_di, b_mem_do;

    logic [7:0]  ram_a [0:65535];
    logic [7:0]  ram_b [0:65535];
    logic [7:0]  rd_a;
    logic [7:0]  pipe_b [0:2];

    logic        prev_we_a, prev_we_b;
    int          we_cnt_a;
    logic [15:0] we_addr_a;
    logic [7:0]  we_di_a;
    logic        mdl_last;
    logic [7:0]  mdl_mem [0:7];

    ram_arbiter #(.AW(16), .DW(8), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_di(mem_di), .mem_do(mem_do)
    );

    ram_arbiter #(.AW(16), .DW(8), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
        .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
        .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
        .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
        .mem_addr(b_mem_addr), .mem_we(b_mem_we), .mem_di(b_mem_di), .mem_do(b_mem_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models: one-cycle read for dut, three-stage read pipeline for dut3
    always @(posedge clk) begin
        if (mem_we) ram_a[mem_addr] <= mem_di;
        rd_a <= ram_a[mem_addr];
        if (b_mem_we) ram_b[b_mem_addr] <= b_mem_di;
        pipe_b[0] <= ram_b[b_mem_addr];
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign mem_do   = rd_a;
    assign b_mem_do = pipe_b[2];

    // Continuous protocol monitor: exclusive acks, isolated write strobes
    always @(negedge clk) begin
        if (m0_ack || m1_ack) begin
            checks++;
            if (m0_ack && m1_ack) begin
                errors++;
                $display("FAIL both_acks_a: m0_ack=%b m1_ack=%b, required at most one high", m0_ack, m1_ack);
            end
        end
        if (b_m0_ack || b_m1_ack) begin
            checks++;
            if (b_m0_ack && b_m1_ack) begin
                errors++;
                $display("FAIL both_acks_b: m0_ack=%b m1_ack=%b, required at most one high", b_m0_ack, b_m1_ack);
            end
        end
        if (mem_we) begin
            checks++;
            we_cnt_a++;
            we_addr_a = mem_addr;
            we_di_a   = mem_di;
            if (prev_we_a) begin
                errors++;
                $display("FAIL mem_we_consecutive_a: mem_we high on two cycles in a row, required single cycle");
            end
        end
        if (b_mem_we) begin
            checks++;
            if (prev_we_b) begin
                errors++;
                $display("FAIL mem_we_consecutive_b: mem_we high on two cycles in a row, required single cycle");
            end
        end
        prev_we_a = mem_we;
        prev_we_b = b_mem_we;
    end

    function automatic int lat(input logic we, input int rdl);
        return we ? 2 : 2 + rdl;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0; b_m0_req = 1'b0; b_m1_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        mdl_last = 1'b1;
        @(negedge clk);
    endtask

    // Drive one request per selected master on dut; each drops req on its ack.
    task automatic run_pair(input logic r0, input logic r1, input logic w0, input logic w1,
                            input logic [15:0] a0, input logic [15:0] a1,
                            input logic [7:0] d0, input logic [7:0] d1,
                            output int c0, output int c1, output logic [7:0] rd0,
                            output logic [7:0] rd1, output int n0, output int n1);
        int last_k;
        c0 = -1; c1 = -1; n0 = 0; n1 = 0; rd0 = 8'h00; rd1 = 8'h00; last_k = 0;
        m0_we = w0; m0_addr = a0; m0_wdata = d0; m0_req = r0;
        m1_we = w1; m1_addr = a1; m1_wdata = d1; m1_req = r1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1 && !(r0 && r1)) begin
                m0_addr = 16'($urandom); m0_wdata = 8'($urandom); m0_we = 1'($urandom);
                m1_addr = 16'($urandom); m1_wdata = 8'($urandom); m1_we = 1'($urandom);
            end
            if (m0_ack) begin
                n0++;
                if (c0 < 0) begin c0 = k; rd0 = m0_rdata; end
                m0_req = 1'b0;
                last_k = k;
            end
            if (m1_ack) begin
                n1++;
                if (c1 < 0) begin c1 = k; rd1 = m1_rdata; end
                m1_req = 1'b0;
                last_k = k;
            end
            if ((!r0 || c0 >= 0) && (!r1 || c1 >= 0) && k >= last_k + 3) break;
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        m0_req = 1'b1; m1_req = 1'b1; b_m0_req = 1'b1; b_m1_req = 1'b1;
        m0_we = 1'b1; m1_we = 1'b1; b_m0_we = 1'b1; b_m1_we = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({m0_ack, m1_ack, mem_we, mem_addr, mem_di, m0_rdata, m1_rdata} !== 43'd0) begin
            errors++;
            $display("FAIL reset_a: outputs=%h, required 0", {m0_ack, m1_ack, mem_we, mem_addr, mem_di, m0_rdata, m1_rdata});
        end
        checks++;
        if ({b_m0_ack, b_m1_ack, b_mem_we, b_mem_addr, b_mem_di, b_m0_rdata, b_m1_rdata} !== 43'd0) begin
            errors++;
            $display("FAIL reset_b: outputs=%h, required 0", {b_m0_ack, b_m1_ack, b_mem_we, b_mem_addr, b_mem_di, b_m0_rdata, b_m1_rdata});
        end
        do_reset();
    endtask

    task automatic test_write_read();
        int c0, c1, n0, n1;
        logic [7:0] rd0, rd1;
        do_reset();
        we_cnt_a = 0;
        run_pair(1'b1, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 8'hA5, 8'h00, c0, c1, rd0, rd1, n0, n1);
        checks++;
        if (c0 !== 2 || n0 !== 1) begin
            errors++; $display("FAIL write_latency: ack at cycle %0d count %0d, required cycle 2 count 1", c0, n0);
        end
        checks++;
        if (we_cnt_a !== 1 || we_addr_a !== 16'h0010 || we_di_a !== 8'hA5) begin
            errors++; $display("FAIL write_strobe: we cycles %0d addr %h di %h, required 1 0010 a5", we_cnt_a, we_addr_a, we_di_a);
        end
        checks++;
        if (ram_a[16'h0010] !== 8'hA5) begin
            errors++; $display("FAIL write_ram: ram[0010]=%h, required a5", ram_a[16'h0010]);
        end
        run_pair(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 8'h00, 8'h00, c0, c1, rd0, rd1, n0, n1);
        checks++;
        if (c0 !== 3 || rd0 !== 8'hA5) begin
            errors++; $display("FAIL read_lat1: ack cycle %0d rdata %h, required 3 a5", c0, rd0);
        end
        checks++;
        if (m1_rdata !== 8'h00 || m0_rdata !== 8'hA5) begin
            errors++; $display("FAIL rdata_isolation: m0_rdata %h m1_rdata %h, required a5 00", m0_rdata, m1_rdata);
        end
    endtask

    task automatic test_early_drop();
        int got;
        got = -1;
        m0_we = 1'b0; m0_addr = 16'h0010; m0_req = 1'b1;
        @(negedge clk);
        m0_req = 1'b0;
        for (int k = 2; k <= 10; k++) begin
            @(negedge clk);
            if (m0_ack && got < 0) got = k;
        end
        checks++;
        if (got !== 3 || m0_rdata !== 8'hA5) begin
            errors++; $display("FAIL early_drop: ack cycle %0d rdata %h, required 3 a5", got, m0_rdata);
        end
    endtask

    task automatic test_same_cycle();
        int c0, c1, n0, n1;
        logic [7:0] rd0, rd1;
        do_reset();
        run_pair(1'b1, 1'b1, 1'b1, 1'b1, 16'h0020, 16'h0021, 8'h11, 8'h22, c0, c1, rd0, rd1, n0, n1);
        checks++;
        if (c0 !== 2 || c1 !== 5 || n0 !== 1 || n1 !== 1) begin
            errors++; $display("FAIL tie_order: m0 ack %0d m1 ack %0d, required 2 5", c0, c1);
        end
        checks++;
        if (ram_a[16'h0020] !== 8'h11 || ram_a[16'h0021] !== 8'h22) begin
            errors++; $display("FAIL tie_ram: ram[20]=%h ram[21]=%h, required 11 22", ram_a[16'h0020], ram_a[16'h0021]);
        end
    endtask

    task automatic test_back_to_back();
        int who[$];
        int cyc[$];
        do_reset();
        m0_we = 1'b1; m0_addr = 16'h0050; m0_wdata = 8'h01; m0_req = 1'b1;
        m1_we = 1'b1; m1_addr = 16'h0051; m1_wdata = 8'h02; m1_req = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (m0_ack) begin who.push_back(0); cyc.push_back(k); end
            if (m1_ack) begin who.push_back(1); cyc.push_back(k); end
            if (who.size() >= 6) begin
                m0_req = 1'b0; m1_req = 1'b0;
                break;
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (who.size() !== 6) begin
            errors++; $display("FAIL rr_count: %0d grants, required 6", who.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (who[i] !== (i % 2) || cyc[i] !== 2 + 3 * i) begin
                    errors++; $display("FAIL rr_order[%0d]: master %0d at cycle %0d, required master %0d at cycle %0d",
                                       i, who[i], cyc[i], i % 2, 2 + 3 * i);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int acks, c0, c1, n0, n1;
        logic [7:0] rd0, rd1;
        do_reset();
        we_cnt_a = 0;
        acks = 0;
        m1_we = 1'b1; m1_addr = 16'h0030; m1_wdata = 8'h5A; m1_req = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        m1_req = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0) begin
            errors++; $display("FAIL reset_we_async: mem_we=%b, required 0", mem_we);
        end
        repeat (4) begin
            @(negedge clk);
            if (m0_ack || m1_ack) acks++;
        end
        rst = 1'b1;
        mdl_last = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (m0_ack || m1_ack) acks++;
        end
        checks++;
        if (acks !== 0 || we_cnt_a !== 0 || ram_a[16'h0030] !== 8'h00) begin
            errors++; $display("FAIL reset_abort: acks %0d we cycles %0d ram[30]=%h, required 0 0 00", acks, we_cnt_a, ram_a[16'h0030]);
        end
        run_pair(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0030, 8'h00, 8'h5A, c0, c1, rd0, rd1, n0, n1);
        checks++;
        if (c1 !== 2 || n1 !== 1 || ram_a[16'h0030] !== 8'h5A) begin
            errors++; $display("FAIL reset_recover: ack cycle %0d count %0d ram[30]=%h, required 2 1 5a", c1, n1, ram_a[16'h0030]);
        end
    endtask

    task automatic test_rdlat3();
        int got, addr_bad;
        got = -1; addr_bad = 0;
        b_m1_we = 1'b0; b_m1_addr = 16'h0040; b_m1_wdata = 8'h00; b_m1_req = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (got < 0 && b_mem_addr !== 16'h0040) addr_bad++;
            if (b_m1_ack && got < 0) begin
                got = k;
                b_m1_req = 1'b0;
            end
        end
        b_m1_req = 1'b0;
        checks++;
        if (got !== 5 || b_m1_rdata !== 8'hC3) begin
            errors++; $display("FAIL read_lat3: ack cycle %0d rdata %h, required 5 c3", got, b_m1_rdata);
        end
        checks++;
        if (addr_bad !== 0 || b_m0_rdata !== 8'h00) begin
            errors++; $display("FAIL lat3_addr_hold: %0d unstable cycles m0_rdata %h, required 0 00", addr_bad, b_m0_rdata);
        end
    endtask

    task automatic test_random();
        logic [1:0]  mode;
        logic        r [2];
        logic        w [2];
        logic [15:0] a [2];
        logic [7:0]  d [2];
        logic [7:0]  exp_rd [2];
        int          ec [2];
        int          order [2];
        int          cnt, c0, c1, n0, n1;
        logic [7:0]  rd0, rd1;
        do_reset();
        exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
        for (int i = 0; i < 8; i++) mdl_mem[i] = 8'h00;
        for (int it = 0; it < 24; it++) begin
            mode = 2'($urandom_range(1, 3));
            r[0] = mode[0]; r[1] = mode[1];
            for (int m = 0; m < 2; m++) begin
                w[m] = 1'($urandom_range(0, 1));
                a[m] = 16'h0100 + 16'($urandom_range(0, 7));
                d[m] = 8'($urandom);
                ec[m] = -1;
            end
            if (r[0] && r[1]) begin
                order[0] = mdl_last ? 0 : 1;
                order[1] = 1 - order[0];
                cnt = 2;
            end else begin
                order[0] = r[0] ? 0 : 1;
                order[1] = 0;
                cnt = 1;
            end
            for (int j = 0; j < cnt; j++) begin
                ec[order[j]] = (j == 0) ? lat(w[order[j]], 1) : ec[order[0]] + 1 + lat(w[order[j]], 1);
                if (w[order[j]]) mdl_mem[a[order[j]][2:0]] = d[order[j]];
                else exp_rd[order[j]] = mdl_mem[a[order[j]][2:0]];
                mdl_last = 1'(order[j]);
            end
            run_pair(r[0], r[1], w[0], w[1], a[0], a[1], d[0], d[1], c0, c1, rd0, rd1, n0, n1);
            if (r[0]) begin
                checks++;
                if (c0 !== ec[0] || n0 !== 1 || (!w[0] && rd0 !== exp_rd[0])) begin
                    errors++; $display("FAIL rand_m0[%0d]: ack %0d count %0d rdata %h, required ack %0d count 1 rdata %h",
                                       it, c0, n0, rd0, ec[0], exp_rd[0]);
                end
            end
            if (r[1]) begin
                checks++;
                if (c1 !== ec[1] || n1 !== 1 || (!w[1] && rd1 !== exp_rd[1])) begin
                    errors++; $display("FAIL rand_m1[%0d]: ack %0d count %0d rdata %h, required ack %0d count 1 rdata %h",
                                       it, c1, n1, rd1, ec[1], exp_rd[1]);
                end
            end
            checks++;
            if (m0_rdata !== exp_rd[0] || m1_rdata !== exp_rd[1]) begin
                errors++; $display("FAIL rand_rdata_hold[%0d]: %h %h, required %h %h", it, m0_rdata, m1_rdata, exp_rd[0], exp_rd[1]);
            end
        end
    endtask

    initial begin
        errors = 0; checks = 0; we_cnt_a = 0; mdl_last = 1'b1;
        prev_we_a = 1'b0; prev_we_b = 1'b0;
        rst = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 16'h0000; m0_wdata = 8'h00;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 16'h0000; m1_wdata = 8'h00;
        b_m0_req = 1'b0; b_m0_we = 1'b0; b_m0_addr = 16'h0000; b_m0_wdata = 8'h00;
        b_m1_req = 1'b0; b_m1_we = 1'b0; b_m1_addr = 16'h0000; b_m1_wdata = 8'h00;
        for (int i = 0; i < 65536; i++) begin
            ram_a[i] <= 8'h00;
            ram_b[i] <= 8'h00;
        end
        ram_b[16'h0040] <= 8'hC3;
        test_reset();
        test_write_read();
        test_early_drop();
        test_same_cycle();
        test_back_to_back();
        test_reset_mid();
        test_rdlat3();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-master arbiter for the single-port system RAM (16-bit address, 8-bit data, synchronous read).
- Master 0 is the CPU load/store path. Master 1 is a secondary requester, e.g. a ROM loader or debug/DMA port.
- Serialises requests with a req/ack handshake and round-robin fairness, and owns the RAM addr/we/di pins.
- Instantiated between the masters and `ram`.

Parameters:
- AW, 16, address width.
- DW, 8, data width.
- RD_LAT, 1, RAM read latency in cycles from the address-sampling edge to valid `mem_do`; legal range 1..4.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- m0_req  in  1  master 0 request; held high until m0_ack.
- m0_we  in  1  master 0 write enable (1 = write, 0 = read).
- m0_addr  in  AW  master 0 address.
- m0_wdata  in  DW  master 0 write data.
- m0_ack  out  1  one-cycle completion pulse.
- m0_rdata  out  DW  read data; valid while m0_ack is high, held afterwards.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata  same as the m0 set, for master 1.
- mem_addr  out  AW  RAM address.
- mem_we  out  1  RAM write strobe.
- mem_di  out  DW  RAM write data.
- mem_do  in  DW  RAM read data.

Behaviour:
- Reset (rst low, asynchronous), all outputs low or zero:
  - state = IDLE; m0_ack, m1_ack, mem_we = 0.
  - mem_addr, mem_di, m0_rdata, m1_rdata = 0.
  - last_grant = 1, so master 0 wins the first tie.
  - wait counter = 0.
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one req high: grant that master.
  - Both high: grant the master != last_grant.
  - On grant: latch the winner's addr/we/wdata into internal registers, record the winner, set last_grant = winner, go to ACCESS.
- ACCESS (exactly one cycle):
  - mem_addr = latched addr, mem_di = latched wdata, mem_we = latched we.
  - Write: go to DONE.
  - Read: load counter with RD_LAT-1 and go to WAIT.
- WAIT:
  - mem_we = 0, mem_addr held.
  - Decrement the counter each cycle; when it reaches 0, capture mem_do into the granted master's rdata register and go to DONE.
- DONE (exactly one cycle):
  - Granted master's ack = 1; the other ack = 0.
  - Go to IDLE. No arbitration occurs in DONE, so a master dropping req the cycle after ack is never re-granted.
- Latency, request sampled in IDLE to ack:
  - Write = 2 cycles (IDLE→ACCESS→DONE).
  - Read = 2 + RD_LAT cycles.
  - Back-to-back throughput: one write per 3 cycles, one read per 3 + RD_LAT cycles.
- mem_we is high only in ACCESS cycles of writes; never two consecutive cycles.
- mem_addr and mem_di hold their last value when idle.
- Only the granted master's rdata is updated; the other master's rdata is unchanged.
- Request signals are sampled only in IDLE. Changes to the addr/we/wdata of a granted master after grant are ignored.
- req dropped before ack (protocol violation): the transaction still completes and ack still pulses.
- Starvation bound: with both masters requesting continuously, grants strictly alternate.
- Reset asserted mid-transaction:
  - Abort immediately, no ack.
  - A write not yet past its ACCESS edge is not performed (mem_we forced 0 asynchronously).
- Concurrent acks on both masters are impossible; assertion-checked in the bench.

Test Plan:
1. Reset, then m0 write addr 0x0010 data 0xA5:
   - mem_we high for exactly 1 cycle with mem_addr = 0x0010, mem_di = 0xA5.
   - m0_ack 2 cycles after req sampled.
2. m0 read 0x0010 after scenario 1, RD_LAT = 1:
   - m0_ack 3 cycles after req sampled, m0_rdata = 0xA5.
   - m1_rdata unchanged (0x00).
3. m0 and m1 both request in the same cycle after reset (m0 write 0x0020 = 0x11, m1 write 0x0021 = 0x22):
   - m0 acked first, m1 acked 3 cycles later.
   - RAM[0x20] = 0x11, RAM[0x21] = 0x22.
4. Both masters hold req continuously for 6 transactions:
   - Grant order m0, m1, m0, m1, m0, m1.
   - No cycle with both acks high.
   - mem_we never high on consecutive cycles.
5. m1 write 0x0030 = 0x5A; rst driven low in the IDLE→ACCESS transition cycle, then released:
   - No m1_ack; mem_we stays 0; RAM[0x30] unchanged.
   - Next m1 request completes normally.
6. RD_LAT = 3 build, m1 read of preloaded 0x0040 = 0xC3:
   - m1_ack 5 cycles after req sampled, m1_rdata = 0xC3.
   - mem_addr stable at 0x0040 through WAIT.
